// File: rtl/demux32_1_4_pkg.sv
// demux32_1_4 shared definitions: channel count, select
// encodings, default geometry and the select decoder.
package demux32_1_4_pkg;

   localparam int NUM_CH    = 4;
   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 2;

   typedef enum logic [1:0] {
      CH_A = 2'b00,
      CH_B = 2'b01,
      CH_C = 2'b10,
      CH_D = 2'b11
   } ch_sel_e;

   // Binary channel select to one-hot channel enable.
   function automatic logic [NUM_CH-1:0] ch_decode(
      input logic [1:0] sel
   );
      logic [NUM_CH-1:0] oh;
      oh = '0;
      unique case (ch_sel_e'(sel))
         CH_A:    oh = 4'b0001;
         CH_B:    oh = 4'b0010;
         CH_C:    oh = 4'b0100;
         CH_D:    oh = 4'b1000;
         default: oh = '0;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/demux32_1_4_chan_fifo.sv
// chan_fifo: one synchronous per-channel FIFO.
// Ports: clk, rst_n (sync, active-low), push/wr_data in,
//        pop in, head/full/empty/level out.
module chan_fifo
   import demux32_1_4_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int LW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [LW-1:0]    cnt;
   logic [WIDTH-1:0] last;
   logic             do_push;
   logic             do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == LW'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign level   = cnt;

   // An empty channel keeps showing the word it last
   // delivered, so the data port never shows stale RAM.
   assign head = empty ? last : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst_n && do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         last   <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            last   <= mem[rd_ptr];
            rd_ptr <= rd_ptr + PW'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   cnt <= cnt + LW'(1);
            2'b01:   cnt <= cnt - LW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/demux32_1_4.sv
// demux32_1_4: buffered 1-to-4 word distributor.
// Ports: clk, rst_n (sync, active-low); producer side
//        in_valid/in_ready/select/in_data; consumer side
//        out_valid[3:0]/out_ready[3:0], heads A..D and
//        occupancies level_A..level_D.
module demux32_1_4
   import demux32_1_4_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int LW    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        select,
   input  logic [WIDTH-1:0]  in_data,
   output logic [NUM_CH-1:0] out_valid,
   input  logic [NUM_CH-1:0] out_ready,
   output logic [WIDTH-1:0]  A,
   output logic [WIDTH-1:0]  B,
   output logic [WIDTH-1:0]  C,
   output logic [WIDTH-1:0]  D,
   output logic [LW-1:0]     level_A,
   output logic [LW-1:0]     level_B,
   output logic [LW-1:0]     level_C,
   output logic [LW-1:0]     level_D
);

   logic [NUM_CH-1:0] full;
   logic [NUM_CH-1:0] empty;
   logic [NUM_CH-1:0] push_en;
   logic [WIDTH-1:0]  head [NUM_CH];
   logic [LW-1:0]     lvl  [NUM_CH];

   // Ready depends only on the addressed channel's state,
   // never on any consumer's out_ready.
   assign in_ready = ~full[select];

   assign push_en = (in_valid && in_ready)
                  ? ch_decode(select)
                  : '0;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      chan_fifo #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH),
         .LW    (LW)
      ) u_fifo (
         .clk     (clk),
         .rst_n   (rst_n),
         .push    (push_en[i]),
         .wr_data (in_data),
         .pop     (out_ready[i]),
         .head    (head[i]),
         .full    (full[i]),
         .empty   (empty[i]),
         .level   (lvl[i])
      );
   end

   assign out_valid = ~empty;

   assign A = head[0];
   assign B = head[1];
   assign C = head[2];
   assign D = head[3];

   assign level_A = lvl[0];
   assign level_B = lvl[1];
   assign level_C = lvl[2];
   assign level_D = lvl[3];

endmodule

// File: tb/tb_demux32_1_4.sv
// tb_demux32_1_4: scoreboard bench for demux32_1_4.
// Per-channel queues model the FIFOs cycle by cycle.
module tb_demux32_1_4;
   import demux32_1_4_pkg::*;

   localparam int W   = 32;
   localparam int DEP = 2;
   localparam int L   = $clog2(DEP + 1);

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [1:0]   select = 2'b00;
   logic [W-1:0] in_data = '0;
   logic [3:0]   out_valid;
   logic [3:0]   out_ready = 4'b0000;
   logic [W-1:0] ch_a, ch_b, ch_c, ch_d;
   logic [L-1:0] lv_a, lv_b, lv_c, lv_d;

   logic [W-1:0] head [4];
   logic [L-1:0] lvl  [4];

   logic [W-1:0] q [4][$];
   logic [W-1:0] last_pop [4];

   int errors = 0;
   int checks = 0;
   bit mon_en = 1'b0;

   demux32_1_4 #(.WIDTH(W), .DEPTH(DEP), .LW(L)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .select    (select),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .A         (ch_a),
      .B         (ch_b),
      .C         (ch_c),
      .D         (ch_d),
      .level_A   (lv_a),
      .level_B   (lv_b),
      .level_C   (lv_c),
      .level_D   (lv_d)
   );

   always #5 clk = ~clk;

   assign head[0] = ch_a;
   assign head[1] = ch_b;
   assign head[2] = ch_c;
   assign head[3] = ch_d;
   assign lvl[0]  = lv_a;
   assign lvl[1]  = lv_b;
   assign lvl[2]  = lv_c;
   assign lvl[3]  = lv_d;

   // Scoreboard: compare current state, then apply the
   // pushes/pops the next rising edge will perform.
   always @(negedge clk) begin
      logic         exp_v;
      logic         exp_r;
      logic [W-1:0] exp_h;
      if (mon_en) begin
         for (int i = 0; i < 4; i++) begin
            exp_v = (q[i].size() != 0);
            exp_h = exp_v ? q[i][0] : last_pop[i];
            checks++;
            if (out_valid[i] !== exp_v) begin
               errors++;
               $display("FAIL valid[%0d] got=%b exp=%b",
                        i, out_valid[i], exp_v);
            end
            checks++;
            if (lvl[i] !== L'(q[i].size())) begin
               errors++;
               $display("FAIL level[%0d] got=%0d exp=%0d",
                        i, lvl[i], q[i].size());
            end
            checks++;
            if (head[i] !== exp_h) begin
               errors++;
               $display("FAIL head[%0d] got=%h exp=%h",
                        i, head[i], exp_h);
            end
         end
         exp_r = (q[select].size() < DEP);
         checks++;
         if (in_ready !== exp_r) begin
            errors++;
            $display("FAIL in_ready sel=%0d got=%b exp=%b",
                     select, in_ready, exp_r);
         end
         if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
               q[i].delete();
               last_pop[i] = '0;
            end
         end else begin
            for (int i = 0; i < 4; i++) begin
               if (out_ready[i] && q[i].size() != 0) begin
                  last_pop[i] = q[i].pop_front();
               end
            end
            if (in_valid && exp_r) begin
               q[select].push_back(in_data);
            end
         end
      end
   end

   task automatic test_reset();
      rst_n    = 1'b0;
      in_valid = 1'b1;
      select   = 2'b01;
      in_data  = 32'hDEADBEEF;
      out_ready = 4'b1111;
      repeat (2) @(posedge clk);
      #1;
      rst_n    = 1'b1;
      in_valid = 1'b0;
      out_ready = 4'b0000;
      #1;
      checks++;
      if (out_valid !== 4'b0000) begin
         errors++;
         $display("FAIL rst_valid got=%b exp=0000",
                  out_valid);
      end
      checks++;
      if ({lv_a, lv_b, lv_c, lv_d} !== '0) begin
         errors++;
         $display("FAIL rst_levels got=%0d %0d %0d %0d",
                  lv_a, lv_b, lv_c, lv_d);
      end
      checks++;
      if ({ch_a, ch_b, ch_c, ch_d} !== '0) begin
         errors++;
         $display("FAIL rst_data got=%h %h %h %h exp=0",
                  ch_a, ch_b, ch_c, ch_d);
      end
      for (int s = 0; s < 4; s++) begin
         select = 2'(s);
         #1;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_ready sel=%0d got=%b exp=1",
                     s, in_ready);
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         q[i].delete();
         last_pop[i] = '0;
      end
      mon_en = 1'b1;
   endtask

   task automatic test_routing();
      out_ready = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         if (k > 0) begin
            checks++;
            if (out_valid !== 4'(1 << (k - 1))) begin
               errors++;
               $display("FAIL route_valid k=%0d got=%b", k,
                        out_valid);
            end
         end
         in_valid = 1'b1;
         select   = 2'(k);
         in_data  = 32'h11111111 * (k + 1);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 4'b1000 || ch_d !== 32'h44444444) begin
         errors++;
         $display("FAIL route_last got=%b %h exp=1000 44444444",
                  out_valid, ch_d);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 4'b0000) begin
         errors++;
         $display("FAIL route_idle got=%b exp=0000", out_valid);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 4'b1011;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b1;
         select   = 2'b10;
         in_data  = 32'hC0C0C0C0 + 32'(k);
      end
      #1;
      checks++;
      if (in_ready !== 1'b0 || lv_c !== L'(2)) begin
         errors++;
         $display("FAIL bp_full rdy=%b lvl=%0d exp 0/2",
                  in_ready, lv_c);
      end
      @(posedge clk);
      #1;
      select  = 2'b00;
      in_data = 32'hA0A0A0A0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_other rdy=%b exp=1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 4'b1111;
      #1;
      checks++;
      if (ch_c !== 32'hC0C0C0C0 || lv_c !== L'(2)) begin
         errors++;
         $display("FAIL bp_head0 got=%h/%0d exp=c0c0c0c0/2",
                  ch_c, lv_c);
      end
      @(posedge clk);
      #1;
      checks++;
      if (ch_c !== 32'hC0C0C0C1 || lv_c !== L'(1)) begin
         errors++;
         $display("FAIL bp_head1 got=%h/%0d exp=c0c0c0c1/1",
                  ch_c, lv_c);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid[2] !== 1'b0 || ch_c !== 32'hC0C0C0C1) begin
         errors++;
         $display("FAIL bp_hold got=%b %h exp=0 c0c0c0c1",
                  out_valid[2], ch_c);
      end
   endtask

   task automatic test_simul();
      out_ready = 4'b1101;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      select   = 2'b01;
      in_data  = 32'hB0000000;
      @(posedge clk);
      #1;
      out_ready = 4'b1111;
      in_data   = 32'hB0000001;
      checks++;
      if (lv_b !== L'(1)) begin
         errors++;
         $display("FAIL simul_pre got=%0d exp=1", lv_b);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checks++;
      if (lv_b !== L'(1) || ch_b !== 32'hB0000001) begin
         errors++;
         $display("FAIL simul_post got=%0d %h exp=1 b0000001",
                  lv_b, ch_b);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid[1] !== 1'b0) begin
         errors++;
         $display("FAIL simul_drain got=%b exp=0",
                  out_valid[1]);
      end
   endtask

   task automatic test_wrap();
      int n   = 0;
      int got = 0;
      int cyc = 0;
      out_ready = 4'b0111;
      while (got < 10 && cyc < 300) begin
         @(posedge clk);
         #1;
         out_ready[3] = 1'($urandom_range(0, 1));
         if (n < 10) begin
            in_valid = 1'b1;
            select   = 2'b11;
            in_data  = 32'(n);
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (in_valid && in_ready) n++;
         if (out_valid[3] && out_ready[3]) begin
            checks++;
            if (ch_d !== 32'(got)) begin
               errors++;
               $display("FAIL wrap_order got=%h exp=%h",
                        ch_d, 32'(got));
            end
            got++;
         end
         checks++;
         if (lv_d > L'(DEP) ||
             (in_ready && lv_d == L'(DEP))) begin
            errors++;
            $display("FAIL wrap_level lvl=%0d rdy=%b",
                     lv_d, in_ready);
         end
         cyc++;
      end
      in_valid = 1'b0;
      checks++;
      if (got != 10) begin
         errors++;
         $display("FAIL wrap_timeout got=%0d exp=10", got);
      end
   endtask

   task automatic test_midreset();
      out_ready = 4'b0000;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b1;
         select   = (k == 0) ? 2'b00 : 2'b10;
         in_data  = 32'h5A000000 + 32'(k);
      end
      @(posedge clk);
      #1;
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      select    = 2'b00;
      in_data   = 32'hDEADDEAD;
      out_ready = 4'b1111;
      #1;
      checks++;
      if (lv_a !== L'(1) || lv_c !== L'(2)) begin
         errors++;
         $display("FAIL mid_pre got=%0d %0d exp=1 2",
                  lv_a, lv_c);
      end
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 4'b0000 ||
          {ch_a, ch_b, ch_c, ch_d} !== '0) begin
         errors++;
         $display("FAIL mid_flush got=%b %h %h", out_valid,
                  ch_a, ch_c);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 4'b0000) begin
         errors++;
         $display("FAIL mid_stale got=%b exp=0000", out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_routing();
      test_backpressure();
      test_simul();
      test_wrap();
      test_midreset();
      @(posedge clk);
      #1;
      mon_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (q[i].size() != 0) begin
            errors++;
            $display("FAIL leftover[%0d] got=%0d exp=0",
                     i, q[i].size());
         end
      end
      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule

// File: doc/demux32_1_4.md
# demux32_1_4

Buffered 1-to-4 word distributor: the write-side counterpart of the 32-bit 4:1 result mux in the datapath. One producer presents a 32-bit word with a 2-bit channel select. The block steers the word into a small per-channel FIFO, and each of the four consumers drains its own channel under an independent valid/ready handshake. A stalled consumer never corrupts or reorders traffic to the other channels.

## Interface
Parameters:
- WIDTH, 32, data word width
- DEPTH, 2, entries per channel FIFO; power of two, ≥ 2
- LW, $clog2(DEPTH+1), width of the level outputs

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous and active-low
- in_valid  in  1  producer has a word
- in_ready  out  1  selected channel can accept a word this cycle
- select  in  2  target channel: 00→A, 01→B, 10→C, 11→D
- in_data  in  WIDTH  word to route
- out_valid  out  4  per-channel head valid; bit0=A … bit3=D
- out_ready  in  4  per-channel consumer ready
- A, B, C, D  out  WIDTH each  head word of each channel
- level_A, level_B, level_C, level_D  out  LW each  channel occupancy

## Operation
- Push: in_valid & in_ready at a rising edge writes in_data into FIFO[select].
- in_ready = !full[select]. It is combinational from select and state only, never from out_ready. There is no pass-through when a channel is full.
- Pop: out_valid[i] & out_ready[i] at a rising edge removes the head of channel i.
- out_valid[i] = (level_i != 0). The head word is presented on port i.
- A/B/C/D and out_valid are stable while out_valid[i] & !out_ready[i].
- Per-channel order is strictly FIFO. There is no ordering relation across channels.
- Push and pop on the same channel in the same cycle:
  - not empty and not full: level unchanged, both take effect.
  - full: pop only, since in_ready was low.
  - empty: push only; the word is not visible until the next cycle.
- Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Level counts 0..DEPTH and never over- or under-flows.
- Data ports for an empty channel hold the last popped value. Consumers ignore them when out_valid is low.
- in_valid=0 means no push, regardless of select and in_data.

## Timing
- Reset (rst_n low at a rising edge) clears all FIFOs and pointers:
  - out_valid=0000, all levels=0, A–D=0.
  - in_ready=1 for any select.
- Reset mid-operation discards all buffered words. Push or pop in the reset cycle is ignored.
- Latency: a word accepted at edge k appears at the output from edge k (visible in cycle k+1) only if the channel was empty before edge k. Otherwise it waits behind older entries.
- Throughput: one push per cycle overall and one pop per cycle per channel. The four channels can all pop in the same cycle.
- No combinational path from out_ready to in_ready, or from in_* to out_*.

## Structure
- Shared package holds:
  - NUM_CH=4.
  - Channel select encodings CH_A=2'b00, CH_B=2'b01, CH_C=2'b10, CH_D=2'b11.
  - Default WIDTH=32 and DEPTH=2.
- Sub-module chan_fifo (WIDTH, DEPTH): synchronous FIFO with push, pop, full, empty, level and head data. It is instantiated four times.
- Top level contains only the select decoder (push enable per channel) and the in_ready mux.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, select=01 → after release out_valid=0000, all levels 0, A–D=0, in_ready=1.
- Routing: out_ready=1111; push 0x11111111 sel 00, 0x22222222 sel 01, 0x33333333 sel 10, 0x44444444 sel 11 on consecutive cycles → each word appears only on its own port for exactly one cycle, one cycle after acceptance.
- Backpressure: out_ready[2]=0; push 3 words to sel 10 → first two accepted, level_C=2, in_ready=0 for sel 10; a push to sel 00 in the same stall is accepted; raising out_ready[2] drains both in order.
- Simultaneous push/pop: channel B at level 1 with out_ready[1]=1 and a push to 01 → level_B stays 1; output order matches input order.
- Wrap-around: stream 0..9 through channel D with pseudo-random out_ready[3] → delivered exactly 0..9; level_D never exceeds DEPTH and in_ready never high while level_D=DEPTH.
- Mid-op reset: A holds 1 word and C holds 2, all out_ready=0; one cycle of rst_n=0 → all flushed, out_valid=0000, no stale word appears afterwards.
